sobel_frame_sequencer: RTL and testbench
========================================

# sobel_frame_sequencer

Frame-level controller that sequences the Sobel window datapath. It accepts a pixel stream from the grayscale stage and meters it into the Sobel block: 9 pixels for the first window of a frame, then 3 per subsequent window. It drives the Sobel block's start and pixel-ready strobes, holds upstream off while a window result is outstanding, counts output pixels against a configured frame size, and reports frame completion or datapath timeout.

## Interface
Parameters:
- `PIXEL_WIDTH`, default 8: pixel width, both in and out.
- `CNT_BITS`, default 17: width of the frame output-pixel counter and `cfg_num_px_i`.
- `WAIT_TIMEOUT`, default 15: maximum cycles to wait for a Sobel result before error.

Ports:
- `clk_i` input 1: clock, rising edge.
- `reset_i` input 1: reset, asynchronous, active-high.
- `start_i` input 1: single-cycle frame start request.
- `abort_i` input 1: abort the current frame.
- `cfg_num_px_i` input CNT_BITS: Sobel output pixels per frame; latched on an accepted start.
- `in_px_i` input PIXEL_WIDTH: upstream pixel.
- `in_valid_i` input 1: upstream pixel valid.
- `in_ready_o` output 1: sequencer can accept a pixel; a transfer occurs when `in_valid_i & in_ready_o`.
- `start_sobel_o` output 1: level to the Sobel block, high for the duration of a frame.
- `sobel_px_o` output PIXEL_WIDTH: pixel to the Sobel block.
- `sobel_px_rdy_o` output 1: pixel strobe to the Sobel block.
- `sobel_px_i` input PIXEL_WIDTH: Sobel result.
- `sobel_rdy_i` input 1: Sobel result strobe.
- `out_px_o` output PIXEL_WIDTH: registered result.
- `out_valid_o` output 1: result strobe.
- `frame_done_o` output 1: one-cycle pulse at frame completion.
- `busy_o` output 1: high in any state other than IDLE.
- `err_o` output 1: high in ERROR.

## Operation
- States: IDLE, ARM, FILL, WAIT, STREAM, DONE, ERROR.
- IDLE: all strobes low.
  - `start_i` with `abort_i` low: latch `cfg_num_px_i`, clear counters, go to ARM.
  - If the latched value is 0, go to DONE instead.
- ARM: `start_sobel_o` = 1, `in_ready_o` = 0. Lasts one cycle, then FILL with the window quota at 9.
- FILL / STREAM: `in_ready_o` = 1 while the window pixel count is below quota. The quota is 9 in FILL and 3 in STREAM.
  - Each transfer registers `in_px_i` to `sobel_px_o` and pulses `sobel_px_rdy_o` for one cycle.
  - When the quota is reached, go to WAIT and clear the timer.
- WAIT: `in_ready_o` = 0; the timer increments every cycle.
  - On `sobel_rdy_i`: register `sobel_px_i` to `out_px_o`, pulse `out_valid_o`, and increment the output counter.
  - If the new count equals the latched frame size, go to DONE. Otherwise go to STREAM with the quota at 3.
  - If the timer reaches `WAIT_TIMEOUT` with no `sobel_rdy_i`, go to ERROR.
- DONE: `start_sobel_o` = 0 and `frame_done_o` = 1 for one cycle, then IDLE. This returns the Sobel block to first-window fill.
- ERROR: `err_o` = 1 and `start_sobel_o` = 0. Stays until `abort_i`, then goes to IDLE.
- `abort_i` in any non-IDLE state: IDLE on the next cycle.
  - `start_sobel_o` drops, no `frame_done_o`, and a pending result is dropped.
  - `abort_i` takes priority over `start_i` and over every other transition.
- `start_i` outside IDLE is ignored. `cfg_num_px_i` changes after the start is latched have no effect on the current frame.
- `sobel_rdy_i` outside WAIT is ignored, with no output strobe.
- Counters:
  - The output counter is CNT_BITS wide. Completion compares it for equality, so it cannot wrap within a legal frame.
  - The window counter is 4 bits. The timer is sized as clog2(WAIT_TIMEOUT+1).

## Timing
- Reset values:
  - `in_ready_o`, `start_sobel_o`, `sobel_px_rdy_o`, `out_valid_o`, `frame_done_o`, `busy_o`, `err_o` are all 0.
  - `sobel_px_o` and `out_px_o` are 0.
  - State is IDLE.
- `start_i` at cycle N:
  - `busy_o` and `start_sobel_o` are high from N+1.
  - `in_ready_o` is high from N+2.
- Upstream transfer at cycle T: `sobel_px_rdy_o` is high at T+1, with no combinational path from `in_valid_i`.
- `sobel_rdy_i` at cycle R: `out_valid_o` is high at R+1.
  - If that result is not the frame's last, `in_ready_o` is high at R+1.
  - If it is the last, `frame_done_o` is high at R+1, `start_sobel_o` is low at R+1, and the state is IDLE at R+2.
- Back-to-back frames: a `start_i` at R+2 is accepted.
- `in_ready_o` is a registered state decode. It drops in the cycle after the quota-completing transfer, so no quota overrun is possible.
- Asserting `reset_i` mid-frame forces all outputs to their reset values immediately, with no clock needed.

## Test plan
- Frame with `cfg_num_px_i`=3, continuous valid, Sobel result 2 cycles after each last pixel.
  - Required: exactly 9+3+3 = 15 transfers and 3 `out_valid_o` pulses with the correct pixels.
  - Required: `frame_done_o` one cycle after the 3rd result, `start_sobel_o` low in that cycle.
- Upstream gaps (valid 1 cycle in 3) during FILL: `sobel_px_rdy_o` pulses track each transfer at +1 cycle, and the count reaches 9 before WAIT.
- `cfg_num_px_i`=0: `start_i` gives a `frame_done_o` pulse at N+1, zero transfers, and `start_sobel_o` never high.
- No `sobel_rdy_i` after the 9th pixel: `err_o`=1 after 15 cycles in WAIT, `in_ready_o`=0; `abort_i` returns to IDLE with `err_o`=0.
- `abort_i` asserted together with `sobel_rdy_i` in WAIT: no `out_valid_o` and no `frame_done_o`; the next `start_i` begins a fresh 9-pixel fill.
- Async `reset_i` pulse mid-STREAM, off clock edge: all outputs are 0 immediately; `start_i` then sees 9-pixel fill.

Source files
------------

// File: rtl/sobel_frame_sequencer.sv
// sobel_frame_sequencer: meters upstream pixels into the Sobel window datapath (9 then 3 per window) and tracks frame completion
module sobel_frame_sequencer #(
  parameter int PIXEL_WIDTH = 8,
  parameter int CNT_BITS = 17,
  parameter int WAIT_TIMEOUT = 15
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [CNT_BITS-1:0]    cfg_num_px_i,
  input  logic [PIXEL_WIDTH-1:0] in_px_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output logic                   start_sobel_o,
  output logic [PIXEL_WIDTH-1:0] sobel_px_o,
  output logic                   sobel_px_rdy_o,
  input  logic [PIXEL_WIDTH-1:0] sobel_px_i,
  input  logic                   sobel_rdy_i,
  output logic [PIXEL_WIDTH-1:0] out_px_o,
  output logic                   out_valid_o,
  output logic                   frame_done_o,
  output logic                   busy_o,
  output logic                   err_o
);
  localparam int TW = $clog2(WAIT_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, ARM, FILL, WAIT, STREAM, DONE, ERROR} state_t;
  state_t state, state_n;
  logic [CNT_BITS-1:0] num_px, out_cnt;
  logic [3:0] win_cnt, quota;
  logic [TW-1:0] timer;
  logic xfer, res, accept;
  assign quota = state == FILL ? 4'd9 : 4'd3;
  assign in_ready_o = (state == FILL || state == STREAM) && win_cnt < quota;
  assign xfer = in_valid_i && in_ready_o;
  assign res = state == WAIT && sobel_rdy_i && !abort_i;
  assign accept = state == IDLE && start_i && !abort_i;
  assign start_sobel_o = state == ARM || state == FILL || state == WAIT || state == STREAM;
  assign frame_done_o = state == DONE;
  assign busy_o = state != IDLE;
  assign err_o = state == ERROR;
  always_comb begin
    state_n = state;
    if (abort_i && state != IDLE) state_n = IDLE;
    else
      case (state)
        IDLE: if (accept) state_n = cfg_num_px_i == '0 ? DONE : ARM;
        ARM: state_n = FILL;
        FILL, STREAM: if (xfer && win_cnt + 4'd1 == quota) state_n = WAIT;
        WAIT:
          if (sobel_rdy_i) state_n = out_cnt + CNT_BITS'(1) == num_px ? DONE : STREAM;
          else if (timer == TW'(WAIT_TIMEOUT - 1)) state_n = ERROR;
        DONE: state_n = IDLE;
        ERROR: state_n = ERROR;
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= IDLE;
      num_px <= '0;
      out_cnt <= '0;
      win_cnt <= '0;
      timer <= '0;
      sobel_px_o <= '0;
      sobel_px_rdy_o <= 1'b0;
      out_px_o <= '0;
      out_valid_o <= 1'b0;
    end else begin
      state <= state_n;
      sobel_px_rdy_o <= xfer && !abort_i;
      out_valid_o <= res;
      win_cnt <= state_n != state ? '0 : win_cnt + 4'(xfer);
      timer <= state == WAIT ? timer + TW'(1) : '0;
      if (xfer) sobel_px_o <= in_px_i;
      if (res) begin
        out_px_o <= sobel_px_i;
        out_cnt <= out_cnt + CNT_BITS'(1);
      end
      if (accept) begin
        num_px <= cfg_num_px_i;
        out_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// tb_sobel_frame_sequencer: table vectors, directed corner sequences and randomized frames against a window-quota model
module tb_sobel_frame_sequencer;
  logic clk_i = 0, reset_i = 1, start_i = 0, abort_i = 0, in_valid_i = 0, sobel_rdy_i = 0;
  logic [16:0] cfg_num_px_i = '0;
  logic [7:0] in_px_i = '0, sobel_px_i = '0;
  logic in_ready_o, start_sobel_o, sobel_px_rdy_o, out_valid_o, frame_done_o, busy_o, err_o;
  logic [7:0] sobel_px_o, out_px_o;
  int tests = 0, fails = 0, seen = 0;
  bit xf_prev = 0;
  logic [7:0] acc_q[$];
  logic [7:0] cur_px = 8'h5a;

  typedef struct {bit start; bit abort; int cfg; bit srdy; bit busy; bit ss; bit ir; bit fd; bit ov;} vec_t;
  vec_t tbl[11];

  always #5 clk_i = ~clk_i;

  sobel_frame_sequencer dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .abort_i(abort_i),
    .cfg_num_px_i(cfg_num_px_i), .in_px_i(in_px_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .start_sobel_o(start_sobel_o), .sobel_px_o(sobel_px_o),
    .sobel_px_rdy_o(sobel_px_rdy_o), .sobel_px_i(sobel_px_i), .sobel_rdy_i(sobel_rdy_i),
    .out_px_o(out_px_o), .out_valid_o(out_valid_o), .frame_done_o(frame_done_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_ir"}, in_ready_o, 0);
    chk({tag, "_ss"}, start_sobel_o, 0);
    chk({tag, "_pxrdy"}, sobel_px_rdy_o, 0);
    chk({tag, "_ov"}, out_valid_o, 0);
    chk({tag, "_fd"}, frame_done_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_err"}, err_o, 0);
    chk({tag, "_sobel_px"}, sobel_px_o, 0);
    chk({tag, "_out_px"}, out_px_o, 0);
  endtask

  task automatic drive_px(input bit v);
    in_valid_i = v;
    in_px_i = cur_px;
    xf_prev = v && in_ready_o;
    if (xf_prev) begin
      acc_q.push_back(cur_px);
      cur_px = 8'($urandom);
    end
  endtask

  task automatic see_px;
    if (sobel_px_rdy_o) begin
      if (acc_q.size() == 0) chk("px_spurious", 1, 0);
      else chk("sobel_px", sobel_px_o, acc_q.pop_front());
      seen++;
    end
  endtask

  task automatic start_frame(input int n);
    cfg_num_px_i = 17'(n);
    start_i = 1;
    in_valid_i = 0;
    sobel_rdy_i = 0;
    tick;
    start_i = 0;
    cfg_num_px_i = 17'($urandom);
    chk("arm_busy", busy_o, 1);
    chk("arm_ss", start_sobel_o, 1);
    chk("arm_ir", in_ready_o, 0);
    seen = 0;
    xf_prev = 0;
  endtask

  task automatic fill9;
    for (int c = 0; c < 100 && seen < 9; c++) begin
      drive_px(1);
      tick;
      see_px();
    end
    chk("fill9_count", seen, 9);
    in_valid_i = 0;
  endtask

  // vmode: 0 continuous valid, 1 valid one cycle in three, 2 random; lat 0 picks a random result latency
  task automatic run_frame(input int n, input int vmode, input int lat);
    int win = 0, quota = 9, results = 0, pend = -1, last_ov = -10;
    bit done = 0;
    logic [7:0] exp_res = '0;
    start_frame(n);
    for (int cyc = 1; cyc < 3000 && !done; cyc++) begin
      drive_px(vmode == 0 || (vmode == 1 && cyc % 3 == 0) || (vmode == 2 && $urandom_range(0, 2) != 0));
      sobel_rdy_i = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          exp_res = 8'($urandom);
          sobel_px_i = exp_res;
          sobel_rdy_i = 1;
          pend = -1;
        end
      end else if (win < quota && $urandom_range(0, 7) == 0) begin
        sobel_px_i = 8'($urandom);
        sobel_rdy_i = 1;
      end
      tick;
      chk("px_rdy_lag", sobel_px_rdy_o, xf_prev);
      if (sobel_px_rdy_o) begin
        see_px();
        win++;
        if (win == quota) pend = lat > 0 ? lat : $urandom_range(1, 10);
      end
      if (out_valid_o) begin
        chk("out_px", out_px_o, exp_res);
        chk("window_full", win, quota);
        results++;
        win = 0;
        quota = 3;
        last_ov = cyc;
      end
      if (frame_done_o) begin
        chk("done_with_last", cyc - last_ov, 0);
        chk("done_ss_low", start_sobel_o, 0);
        chk("done_results", results, n);
        chk("done_xfers", seen, 9 + 3 * (n - 1));
        chk("done_queue_empty", acc_q.size(), 0);
        done = 1;
      end else begin
        chk("frame_ss_high", start_sobel_o, 1);
        if (win >= quota) chk("no_overrun", in_ready_o, 0);
      end
    end
    if (!done) chk("frame_done_seen", 0, 1);
    in_valid_i = 0;
    sobel_rdy_i = 0;
    tick;
    chk("idle_after_done", busy_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 5, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 0, 1, 0, 0, 1, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[5]  = '{1, 0, 1, 0, 1, 1, 0, 0, 0};
    tbl[6]  = '{0, 0, 1, 0, 1, 1, 1, 0, 0};
    tbl[7]  = '{0, 1, 1, 0, 0, 0, 0, 0, 0};
    tbl[8]  = '{1, 0, 2, 0, 1, 1, 0, 0, 0};
    tbl[9]  = '{1, 0, 0, 0, 1, 1, 1, 0, 0};
    tbl[10] = '{0, 1, 0, 0, 0, 0, 0, 0, 0};

    repeat (2) @(posedge clk_i);
    #1;
    all_zero("reset");
    reset_i = 0;
    tick;

    for (int i = 0; i < 11; i++) begin
      start_i = tbl[i].start;
      abort_i = tbl[i].abort;
      cfg_num_px_i = 17'(tbl[i].cfg);
      sobel_rdy_i = tbl[i].srdy;
      tick;
      chk($sformatf("vec%0d_busy", i), busy_o, tbl[i].busy);
      chk($sformatf("vec%0d_ss", i), start_sobel_o, tbl[i].ss);
      chk($sformatf("vec%0d_ir", i), in_ready_o, tbl[i].ir);
      chk($sformatf("vec%0d_fd", i), frame_done_o, tbl[i].fd);
      chk($sformatf("vec%0d_ov", i), out_valid_o, tbl[i].ov);
    end
    start_i = 0;
    abort_i = 0;
    sobel_rdy_i = 0;
    tick;

    run_frame(3, 0, 1);
    run_frame(2, 1, 1);

    start_frame(1);
    fill9();
    in_valid_i = 1;
    for (int i = 1; i <= 14; i++) begin
      tick;
      if (i == 14) chk("timeout_not_early", err_o, 0);
    end
    tick;
    chk("timeout_err", err_o, 1);
    chk("timeout_ir", in_ready_o, 0);
    chk("timeout_ss", start_sobel_o, 0);
    chk("timeout_busy", busy_o, 1);
    tick;
    chk("err_holds", err_o, 1);
    in_valid_i = 0;
    abort_i = 1;
    tick;
    abort_i = 0;
    chk("err_abort_err", err_o, 0);
    chk("err_abort_busy", busy_o, 0);

    start_frame(2);
    fill9();
    sobel_px_i = 8'h3c;
    sobel_rdy_i = 1;
    abort_i = 1;
    tick;
    sobel_rdy_i = 0;
    abort_i = 0;
    chk("abort_rdy_ov", out_valid_o, 0);
    chk("abort_rdy_fd", frame_done_o, 0);
    chk("abort_rdy_busy", busy_o, 0);
    tick;
    chk("abort_rdy_ov2", out_valid_o, 0);
    chk("abort_rdy_fd2", frame_done_o, 0);
    run_frame(1, 0, 2);

    start_frame(2);
    fill9();
    sobel_px_i = 8'ha5;
    sobel_rdy_i = 1;
    tick;
    chk("pre_reset_ov", out_valid_o, 1);
    chk("pre_reset_px", out_px_o, 8'ha5);
    sobel_rdy_i = 0;
    drive_px(1);
    tick;
    chk("pre_reset_pxrdy", sobel_px_rdy_o, 1);
    see_px();
    #2 reset_i = 1;
    #1 all_zero("async_reset");
    reset_i = 0;
    in_valid_i = 0;
    acc_q.delete();
    run_frame(1, 2, 0);

    for (int f = 0; f < 6; f++) run_frame($urandom_range(1, 4), 2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
